// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone B4 round-robin arbiter.
package wb_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } arb_state_t;

   // Number of SEL lines for a given data width and select granularity.
   function automatic int sel_width(input int data_width, input int granularity);
      return data_width / granularity;
   endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational rotating-priority picker: first requester after ptr wins.
module wb_rr_picker #(
   parameter int NUM_MASTERS = 2,
   parameter int PTR_W       = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [PTR_W-1:0]       ptr,
   output logic [NUM_MASTERS-1:0] win_oh,
   output logic                   valid
);

   logic [PTR_W-1:0] cand;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      win_oh = '0;
      valid  = 1'b0;
      cand   = '0;
      // Scan ptr+1, ptr+2, ... so the last winner has the lowest priority.
      for (int i = 0; i < NUM_MASTERS; i++) begin
         cand = PTR_W'((int'(ptr) + 1 + i) % NUM_MASTERS);
         if (!valid && req[cand]) begin
            win_oh[cand] = 1'b1;
            valid        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone B4 classic arbiter, round-robin per CYC tenure.
// Optional slave-stall watchdog enabled by defining WB_ARBITER_TIMEOUT_EN.
module wb_rr_arbiter
   import wb_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int GRANULARITY    = 8,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                                             clk_i,
   input  logic                                             rst_i,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]                m_adr_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]                m_dat_i,
   input  logic [NUM_MASTERS-1:0]                           m_we_i,
   input  logic [NUM_MASTERS*(DATA_WIDTH/GRANULARITY)-1:0]  m_sel_i,
   input  logic [NUM_MASTERS-1:0]                           m_stb_i,
   input  logic [NUM_MASTERS-1:0]                           m_cyc_i,
   output logic [NUM_MASTERS*DATA_WIDTH-1:0]                m_dat_o,
   output logic [NUM_MASTERS-1:0]                           m_ack_o,
   output logic [NUM_MASTERS-1:0]                           m_err_o,
   output logic [ADDR_WIDTH-1:0]                            s_adr_o,
   output logic [DATA_WIDTH-1:0]                            s_dat_o,
   output logic                                             s_we_o,
   output logic [DATA_WIDTH/GRANULARITY-1:0]                s_sel_o,
   output logic                                             s_stb_o,
   output logic                                             s_cyc_o,
   input  logic [DATA_WIDTH-1:0]                            s_dat_i,
   input  logic                                             s_ack_i,
   input  logic                                             s_err_i,
   output logic [NUM_MASTERS-1:0]                           gnt_o
);

   localparam int PTR_W = $clog2(NUM_MASTERS);
   localparam int SEL_W = sel_width(DATA_WIDTH, GRANULARITY);

   if (GRANULARITY != 8 && GRANULARITY != 16 && GRANULARITY != 32) begin : g_bad_gran
      $fatal(1, "wb_rr_arbiter: GRANULARITY must be 8, 16 or 32");
   end
   if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_num
      $fatal(1, "wb_rr_arbiter: NUM_MASTERS must be 2..16");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
      $fatal(1, "wb_rr_arbiter: TIMEOUT_CYCLES must be at least 2");
   end

   arb_state_t             state_q, state_d;
   logic [NUM_MASTERS-1:0] gnt_q, gnt_d, pick_oh;
   logic [PTR_W-1:0]       ptr_q, ptr_d, pick_idx, g;
   logic                   pick_valid;
   logic                   tmo_hit;

   logic [ADDR_WIDTH-1:0]  adr_arr [NUM_MASTERS];
   logic [DATA_WIDTH-1:0]  dat_arr [NUM_MASTERS];
   logic [SEL_W-1:0]       sel_arr [NUM_MASTERS];

   for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
      assign adr_arr[k] = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign dat_arr[k] = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
      assign sel_arr[k] = m_sel_i[k*SEL_W +: SEL_W];
   end

   assign m_dat_o = {NUM_MASTERS{s_dat_i}};
   assign gnt_o   = gnt_q;

   wb_rr_picker #(.NUM_MASTERS(NUM_MASTERS), .PTR_W(PTR_W)) u_picker (
      .req    (m_cyc_i),
      .ptr    (ptr_q),
      .win_oh (pick_oh),
      .valid  (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      g        = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (pick_oh[i]) pick_idx = PTR_W'(i);
         if (gnt_q[i])   g        = PTR_W'(i);
      end
   end

   // Picking only from IDLE enforces the mandatory idle cycle between tenures.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: if (pick_valid) begin
            gnt_d   = pick_oh;
            ptr_d   = pick_idx;
            state_d = GRANTED;
         end
         GRANTED: if (!m_cyc_i[g]) begin
            gnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= PTR_W'(NUM_MASTERS - 1);
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef WB_ARBITER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
   logic [TMO_W-1:0] tmo_q;
   logic             stalled;

   assign stalled = (state_q == GRANTED) && m_cyc_i[g] && m_stb_i[g] && !s_ack_i && !s_err_i;
   assign tmo_hit = stalled && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tmo_q <= '0;
      end else if (state_q != GRANTED || !m_cyc_i[g] || s_ack_i || s_err_i || tmo_hit) begin
         tmo_q <= '0;
      end else if (m_stb_i[g]) begin
         tmo_q <= tmo_q + TMO_W'(1);
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_we_o  = 1'b0;
      s_sel_o = '0;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      m_ack_o = '0;
      m_err_o = '0;
      if (state_q == GRANTED) begin
         s_adr_o    = adr_arr[g];
         s_dat_o    = dat_arr[g];
         s_we_o     = m_we_i[g];
         s_sel_o    = sel_arr[g];
         s_cyc_o    = m_cyc_i[g];
         s_stb_o    = m_stb_i[g] && !tmo_hit;
         m_ack_o[g] = s_ack_i;
         m_err_o[g] = s_err_i || tmo_hit;
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter with two masters.
module tb_wb_rr_arbiter;

   localparam int N  = 2;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SW = DW / 8;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic [N*AW-1:0]   m_adr_i = '0;
   logic [N*DW-1:0]   m_dat_i = '0;
   logic [N-1:0]      m_we_i  = '0;
   logic [N*SW-1:0]   m_sel_i = '0;
   logic [N-1:0]      m_stb_i = '0;
   logic [N-1:0]      m_cyc_i = '0;
   logic [N*DW-1:0]   m_dat_o;
   logic [N-1:0]      m_ack_o, m_err_o, gnt_o;
   logic [AW-1:0]     s_adr_o;
   logic [DW-1:0]     s_dat_o;
   logic              s_we_o, s_stb_o, s_cyc_o;
   logic [SW-1:0]     s_sel_o;
   logic [DW-1:0]     s_dat_i = '0;
   logic              s_ack_i = 1'b0;
   logic              s_err_i = 1'b0;

   int n_pass  = 0;
   int n_total = 0;

   wb_rr_arbiter #(
      .NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .GRANULARITY(8), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
      .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
      .gnt_o(gnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Let combinational outputs settle mid-cycle before sampling.
   task automatic settle();
      #2;
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_gnt", gnt_o, 2'b00);
      check("rst_cyc", s_cyc_o, 1'b0);
      check("rst_stb", s_stb_o, 1'b0);
      check("rst_adr", s_adr_o, 32'h0);
      rst_i = 1'b0;

      // Single master 1 write
      tick();
      m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = 2'b10;
      m_adr_i[AW +: AW] = 32'h100;
      m_dat_i[DW +: DW] = 32'hDEADBEEF;
      m_sel_i[SW +: SW] = 4'hF;
      settle();
      check("t1_no_cyc_yet", s_cyc_o, 1'b0);
      tick(); settle();
      check("t1_gnt", gnt_o, 2'b10);
      check("t1_cyc", s_cyc_o, 1'b1);
      check("t1_adr", s_adr_o, 32'h100);
      check("t1_dat", s_dat_o, 32'hDEADBEEF);
      check("t1_we", s_we_o, 1'b1);
      check("t1_sel", s_sel_o, 4'hF);
      check("t1_noack", m_ack_o, 2'b00);
      tick(); s_ack_i = 1'b1; settle();
      check("t1_ack", m_ack_o, 2'b10);
      tick(); s_ack_i = 1'b0; m_cyc_i = 2'b00; m_stb_i = 2'b00; m_we_i = 2'b00; settle();
      check("t1_rel_cyc", s_cyc_o, 1'b0);
      check("t1_rel_gnt", gnt_o, 2'b10);
      tick(); settle();
      check("t1_idle_gnt", gnt_o, 2'b00);

      // Contention: alternation 0,1,0,1
      tick(); m_cyc_i = 2'b11; m_stb_i = 2'b11;
      tick(); settle();
      check("t2_gnt0", gnt_o, 2'b01);
      s_ack_i = 1'b1; settle();
      check("t2_ack0", m_ack_o, 2'b01);
      tick(); s_ack_i = 1'b0; m_cyc_i = 2'b10; m_stb_i = 2'b10; settle();
      check("t2_rel0_cyc", s_cyc_o, 1'b0);
      tick(); settle();
      check("t2_idle0", gnt_o, 2'b00);
      check("t2_idle0_cyc", s_cyc_o, 1'b0);
      tick(); settle();
      check("t2_gnt1", gnt_o, 2'b10);
      check("t2_gnt1_cyc", s_cyc_o, 1'b1);
      m_cyc_i = 2'b01; m_stb_i = 2'b01;
      tick(); m_cyc_i = 2'b11; m_stb_i = 2'b11; settle();
      check("t2_idle1", gnt_o, 2'b00);
      tick(); settle();
      check("t2_gnt0_again", gnt_o, 2'b01);
      m_cyc_i = 2'b10; m_stb_i = 2'b10;
      tick(); settle();
      check("t2_idle2", gnt_o, 2'b00);
      tick(); settle();
      check("t2_gnt1_again", gnt_o, 2'b10);
      m_cyc_i = 2'b00; m_stb_i = 2'b00;
      tick(); tick();

      // Burst hold: master 0 keeps CYC through three reads
      m_cyc_i = 2'b01; m_stb_i = 2'b01;
      tick();
      m_cyc_i = 2'b11; m_stb_i = 2'b11;
      for (int i = 0; i < 3; i++) begin
         m_adr_i[0 +: AW] = 32'(4 * i);
         s_dat_i = 32'hA000_0000 + 32'(i);
         s_ack_i = 1'b1;
         settle();
         check("t3_gnt_hold", gnt_o, 2'b01);
         check("t3_adr", s_adr_o, 64'(4 * i));
         check("t3_ack", m_ack_o, 2'b01);
         check("t3_rdat", m_dat_o[0 +: DW], 64'(32'hA000_0000 + 32'(i)));
         tick();
      end
      s_ack_i = 1'b0;
      m_cyc_i = 2'b10; m_stb_i = 2'b10; settle();
      check("t3_rel_cyc", s_cyc_o, 1'b0);
      tick(); settle();
      check("t3_idle", gnt_o, 2'b00);
      tick(); settle();
      check("t3_gnt1", gnt_o, 2'b10);

      // Slave error to master 1
      m_we_i = 2'b00;
      s_err_i = 1'b1; settle();
      check("t4_err", m_err_o, 2'b10);
      check("t4_noack", m_ack_o, 2'b00);
      tick(); s_err_i = 1'b0; m_cyc_i = 2'b00; m_stb_i = 2'b00;
      tick(); tick();

      // Reset mid-transfer with master 1 granted
      m_cyc_i = 2'b10; m_stb_i = 2'b10;
      tick(); settle();
      check("t5_pre_gnt", gnt_o, 2'b10);
      check("t5_pre_stb", s_stb_o, 1'b1);
      rst_i = 1'b1; #1;
      check("t5_rst_cyc", s_cyc_o, 1'b0);
      check("t5_rst_stb", s_stb_o, 1'b0);
      check("t5_rst_gnt", gnt_o, 2'b00);
      #1 rst_i = 1'b0;
      m_cyc_i = 2'b11; m_stb_i = 2'b11;
      tick(); settle();
      check("t5_post_gnt0", gnt_o, 2'b01);

      // Stalled slave: watchdog fires in the 8th stalled cycle when enabled
      m_cyc_i = 2'b01; m_stb_i = 2'b01;
      for (int k = 1; k <= 9; k++) begin
         settle();
`ifdef WB_ARBITER_TIMEOUT_EN
         check("t6_err", m_err_o, (k == 8) ? 2'b01 : 2'b00);
         check("t6_stb", s_stb_o, (k == 8) ? 1'b0 : 1'b1);
`else
         check("t6_err", m_err_o, 2'b00);
         check("t6_stb", s_stb_o, 1'b1);
`endif
         tick();
      end
      m_cyc_i = 2'b00; m_stb_i = 2'b00;
      tick(); settle();
      check("t6_end_gnt", gnt_o, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- N-master to 1-slave Wishbone B4 classic arbiter; generalises the single master/slave link to a parametrised master count.
- Round-robin bus ownership, granted per cycle tenure (CYC-framed).
- Sits between CPU/DMA/debug masters and the shared slave-side interconnect or decoder.

Parameters:
NUM_MASTERS, 2, number of master ports (2..16)
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 32, address bus width
GRANULARITY, 8, SEL granularity in bits; only 8/16/32 legal, elaboration $fatal otherwise
TIMEOUT_CYCLES, 256, watchdog limit (used only with the optional feature)

Ports:
clk_i  in  1  single system clock
rst_i  in  1  asynchronous, active-high reset
m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  flattened master addresses, master k at slice k
m_dat_i  in  NUM_MASTERS*DATA_WIDTH  flattened master write data
m_we_i  in  NUM_MASTERS  write enables
m_sel_i  in  NUM_MASTERS*(DATA_WIDTH/GRANULARITY)  byte selects
m_stb_i  in  NUM_MASTERS  strobes
m_cyc_i  in  NUM_MASTERS  cycle requests
m_dat_o  out  NUM_MASTERS*DATA_WIDTH  read data, slave data broadcast to all
m_ack_o  out  NUM_MASTERS  acks, granted master only
m_err_o  out  NUM_MASTERS  errors, granted master only
s_adr_o  out  ADDR_WIDTH  slave address
s_dat_o  out  DATA_WIDTH  slave write data
s_we_o  out  1  slave write enable
s_sel_o  out  DATA_WIDTH/GRANULARITY  slave selects
s_stb_o  out  1  slave strobe
s_cyc_o  out  1  slave cycle
s_dat_i  in  DATA_WIDTH  slave read data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave error
gnt_o  out  NUM_MASTERS  one-hot registered grant (status/debug)

Behaviour:
- Reset (async, rst_i=1): state IDLE, gnt_o=0, last-grant pointer=NUM_MASTERS-1 (master 0 wins first), timeout counter=0. All m_ack_o/m_err_o=0, s_cyc_o=s_stb_o=0. s_adr_o/s_dat_o/s_we_o/s_sel_o=0 while no grant.
- FSM IDLE: if any m_cyc_i is high, pick the first requester scanning pointer+1, pointer+2, … modulo NUM_MASTERS. Register the one-hot grant at the clock edge, update the pointer to the winner, go to GRANTED.
- Grant latency: one cycle from request to s_cyc_o.
- GRANTED, combinational mux from granted index g:
  - s_adr_o/s_dat_o/s_we_o/s_sel_o = master g slices
  - s_cyc_o = m_cyc_i[g]
  - s_stb_o = m_stb_i[g]
  - m_ack_o[g] = s_ack_i, m_err_o[g] = s_err_i; all other acks/errs = 0
- Release: when m_cyc_i[g]=0 in GRANTED, s_cyc_o drops the same cycle. The next edge returns to IDLE with gnt_o=0. Minimum one idle cycle between tenures, with no combinational regrant.
- Master holds CYC across multiple STB/ACK transfers: keeps the bus, no preemption.
- Master drops CYC with ACK outstanding: transfer aborted, arbiter releases normally, late s_ack_i is not forwarded (gnt_o already 0).
- Simultaneous requests: rotating priority guarantees each requester a grant within NUM_MASTERS tenures.
- Non-requesting masters never see ack/err.
- s_ack_i and s_err_i both high: both forwarded unchanged (slave protocol violation, not masked).
- Reset mid-tenure: all outputs drop asynchronously, pointer restored to NUM_MASTERS-1.

Optional Feature:
- Macro WB_ARBITER_TIMEOUT_EN.
- With it: counter increments each GRANTED cycle with s_stb_o=1 and s_ack_i=s_err_i=0, and clears on ack/err, release, or reset.
  - When the count reaches TIMEOUT_CYCLES-1, that cycle forces m_err_o[g]=1 and masks s_stb_o=0, then the counter clears.
  - The master must then end or retry.
- Without it: no counter, no forced error. A stalled slave hangs the bus indefinitely.

Decomposition:
- Package wb_pkg: arb_state_t enum (IDLE, GRANTED); function sel_width(DATA_WIDTH, GRANULARITY).
- Sub-module wb_rr_picker: combinational rotating-priority picker. Inputs are the request vector and pointer; outputs are the one-hot winner and a valid flag. The FSM and pointer register stay in the top module.

Test Plan:
- Single master: master 1 write to adr 0x100, data 0xDEADBEEF, sel 0xF, slave acks after 2 cycles -> s_cyc_o high 1 cycle after request, m_ack_o=2'b10 for one cycle, gnt_o=2'b10.
- Contention: both masters raise cyc together after reset -> master 0 granted first; after release, one idle cycle, then master 1 granted. Repeat: alternates 0,1,0,1.
- Burst hold: master 0 keeps cyc through 3 reads at 0x0/0x4/0x8 while master 1 requests -> master 1 waits until master 0 drops cyc; 3 acks seen only by master 0.
- Slave error: granted master 1 read, s_err_i=1 -> m_err_o=2'b10, m_ack_o=0; master 0 sees nothing.
- Reset mid-transfer: rst_i pulsed while master 1 granted with stb high -> s_cyc_o/s_stb_o/gnt_o 0 immediately; next contention grants master 0.
- Timeout (with WB_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never acks -> m_err_o[g]=1 exactly in the 8th stalled cycle, s_stb_o masked that cycle; no error without the macro.
